ir_nec_tx: RTL and testbench
============================

Name: ir_nec_tx

Overview:
- NEC-protocol infrared transmitter, the send-side counterpart of the IR decoder block.
- Takes a 16-bit address and an 8-bit command and serialises a full NEC frame or an NEC repeat code.
- Drives a 38 kHz-modulated output for an IR LED, plus an unmodulated envelope for loopback into the decoder on the same board.
- Runs on the divided system clock `clk`.

Parameters:
- UNIT_CYC, 28125: clk cycles per 562.5 us NEC time unit (50 MHz clk).
- CARRIER_DIV, 658: clk cycles per carrier half-period (≈38 kHz at 50 MHz).
- EXT_ADDR, 0: 0 = send addr[7:0] then ~addr[7:0]; 1 = send tx_addr[15:0] verbatim.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a full frame; sampled only in IDLE.
- send_rep  in  1  request a repeat code; sampled only in IDLE.
- tx_addr  in  16  address; captured when a request is accepted.
- tx_cmd  in  8  command; captured when a request is accepted.
- busy  out  1  high from request acceptance through end of frame-period gap.
- done  out  1  one-cycle pulse on the last GAP cycle.
- ir_env  out  1  mark envelope: 1 = burst, 0 = space.
- ir_mod  out  1  ir_env AND carrier; drives the LED.
- ir_rx  out  1  ~ir_env; active-low receiver-equivalent level for loopback.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, ir_env=0, ir_mod=0, ir_rx=1; all counters and shift register cleared. Mid-frame reset aborts immediately.
- Timing in units (U):
  - leader mark 16U; leader space 8U (frame) or 4U (repeat).
  - bit mark 1U; bit space 1U for '0', 3U for '1'.
  - stop mark 1U.
  - frame period 192U (≈108 ms), measured from leader start.
- Word transmitted is 32 bits, LSB first per byte, in order:
  - A0 = addr[7:0]
  - A1 = EXT_ADDR ? addr[15:8] : ~addr[7:0]
  - C = cmd
  - ~C
- Word layout {A1,A0,C,~C} matches the decoder's data[31:0]: data[31:16] = address, data[15:8] = command.
- Request acceptance: start=1 or send_rep=1 in IDLE at edge N captures operands. From cycle N+1, busy=1, ir_env=1 and state=LEAD_MARK.
- Simultaneous start and send_rep: start wins.
- Requests while busy are ignored; they are not queued.
- FSM states:
  - IDLE: waits for start or send_rep.
  - LEAD_MARK: 16U, then LEAD_SPACE (frame) or REP_SPACE (repeat).
  - LEAD_SPACE: 8U, then BIT_MARK.
  - REP_SPACE: 4U, then STOP_MARK.
  - BIT_MARK: 1U, then BIT_SPACE.
  - BIT_SPACE: 1U or 3U per current bit; on bit index 31 go to STOP_MARK, otherwise BIT_MARK with the next bit.
  - STOP_MARK: 1U, then GAP.
  - GAP: until frame counter = 192U. On the last GAP cycle done=1; next cycle IDLE with busy=0.
- Counters:
  - unit counter 0..UNIT_CYC-1, wraps.
  - per-state unit count.
  - frame unit counter 0..191 (8 bit) counts from leader start and saturates.
  - 5-bit bit index.
- Carrier:
  - Half-period counter restarts at the first cycle of every mark, so every mark begins carrier-high.
  - Counter is held at 0 during spaces; ir_mod=0 whenever ir_env=0.
- Outputs are registered; no combinational path from inputs to ir_*.

Decomposition:
- Package ir_nec_pkg holds:
  - state enum.
  - unit constants: LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, BIT_U=1, ONE_SPACE_U=3, FRAME_U=192.
- Sub-module ir_carrier(clk, reset, en, CARRIER_DIV) produces the square carrier with phase restart on the rising edge of en.

Test Plan:
- Bench uses UNIT_CYC=4, CARRIER_DIV=1.
- Reset mid-frame (reset low during BIT_SPACE) -> same cycle ir_env=0, ir_rx=1, busy=0; after release, a new start sends a complete frame from leader.
- EXT_ADDR=0, tx_addr=16'h0004, tx_cmd=8'h08, start pulse:
  - ir_env high 64 cycles, low 32 cycles, then bytes 04,FB,08,F7 LSB-first.
  - total ir_env-high = 196 cycles; last mark ends at cycle 484.
  - done at cycle 768; busy low after.
- Loopback of ir_rx into the decoder -> decoder data[31:0]=32'hFB0408F7, data[15:8]=8'h08.
- send_rep pulse -> 64 cycles mark, 16 space, 4 mark; busy for 768 cycles; exactly one done.
- start and send_rep same cycle -> full frame sent; start asserted while busy -> no second frame, exactly one done.
- ir_mod during leader -> toggles every cycle starting high; ir_mod=0 throughout every space.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared types and NEC timing constants for the IR transmitter.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_REP_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } nec_state_t;

    localparam logic [7:0] LEAD_MARK_U  = 8'd16;
    localparam logic [7:0] LEAD_SPACE_U = 8'd8;
    localparam logic [7:0] REP_SPACE_U  = 8'd4;
    localparam logic [7:0] BIT_U        = 8'd1;
    localparam logic [7:0] ONE_SPACE_U  = 8'd3;
    localparam logic [7:0] FRAME_U      = 8'd192;

    function automatic logic is_mark(nec_state_t s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    // Units spent in a state; bit spaces depend on the bit being sent.
    function automatic logic [7:0] state_units(nec_state_t s, logic b);
        logic [7:0] u;
        case (s)
            S_LEAD_MARK:  u = LEAD_MARK_U;
            S_LEAD_SPACE: u = LEAD_SPACE_U;
            S_REP_SPACE:  u = REP_SPACE_U;
            S_BIT_SPACE:  u = b ? ONE_SPACE_U : BIT_U;
            default:      u = BIT_U;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/ir_nec_tx_carrier.sv
// Square-wave IR carrier; phase restarts high on every rising edge of en.
module ir_carrier #(
    parameter int CARRIER_DIV = 658
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic carrier
);

    localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            en_q    <= 1'b0;
            carrier <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                cnt     <= '0;
                carrier <= 1'b0;
            end else if (!en_q) begin
                cnt     <= '0;
                carrier <= 1'b1;
            end else if (cnt == CW'(CARRIER_DIV - 1)) begin
                cnt     <= '0;
                carrier <= ~carrier;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: full frames and repeat codes, modulated
// LED drive plus an unmodulated envelope for loopback.
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYC    = 28125,
    parameter int CARRIER_DIV = 658,
    parameter int EXT_ADDR    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        send_rep,
    input  logic [15:0] tx_addr,
    input  logic [7:0]  tx_cmd,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_mod,
    output logic        ir_rx
);

    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

    nec_state_t    state, state_d;
    logic [UW-1:0] unit_cnt;
    logic [7:0]    st_u;
    logic [7:0]    frame_u;
    logic [4:0]    bit_idx;
    logic [31:0]   shreg;
    logic          rep_q;
    logic          env_q;
    logic          busy_q;
    logic          carrier;

    logic       accept;
    logic       unit_tick;
    logic       st_end;
    logic       frame_end;
    logic [7:0] a1;

    assign accept    = (state == S_IDLE) && (start || send_rep);
    assign unit_tick = (unit_cnt == UW'(UNIT_CYC - 1));
    assign st_end    = unit_tick &&
                       (st_u == state_units(state, shreg[0]) - 8'd1);
    assign frame_end = unit_tick && (frame_u == FRAME_U - 8'd1);
    assign a1        = (EXT_ADDR != 0) ? tx_addr[15:8] : ~tx_addr[7:0];

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:       if (accept) state_d = S_LEAD_MARK;
            S_LEAD_MARK:  if (st_end) state_d = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
            S_LEAD_SPACE: if (st_end) state_d = S_BIT_MARK;
            S_REP_SPACE:  if (st_end) state_d = S_STOP_MARK;
            S_BIT_MARK:   if (st_end) state_d = S_BIT_SPACE;
            S_BIT_SPACE:
                if (st_end) state_d = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:  if (st_end) state_d = S_GAP;
            S_GAP:        if (frame_end) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            unit_cnt <= '0;
            st_u     <= '0;
            frame_u  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rep_q    <= 1'b0;
            env_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state  <= state_d;
            env_q  <= is_mark(state_d);
            busy_q <= (state_d != S_IDLE);
            if (state == S_IDLE) begin
                unit_cnt <= '0;
                st_u     <= '0;
                frame_u  <= '0;
                bit_idx  <= '0;
                if (accept) begin
                    rep_q <= ~start;
                    shreg <= {~tx_cmd, tx_cmd, a1, tx_addr[7:0]};
                end
            end else begin
                unit_cnt <= unit_tick ? '0 : unit_cnt + 1'b1;
                if (unit_tick) begin
                    st_u <= st_end ? 8'd0 : st_u + 8'd1;
                    if (frame_u != FRAME_U - 8'd1)
                        frame_u <= frame_u + 8'd1;
                end
                // Word goes out LSB first: A0, A1, C, ~C.
                if (state == S_BIT_SPACE && st_end) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 5'd1;
                end
            end
        end
    end

    ir_carrier #(
        .CARRIER_DIV(CARRIER_DIV)
    ) u_carrier (
        .clk    (clk),
        .reset  (reset),
        .en     (is_mark(state_d)),
        .carrier(carrier)
    );

    assign busy   = busy_q;
    assign done   = (state == S_GAP) && frame_end;
    assign ir_env = env_q;
    assign ir_mod = env_q & carrier;
    assign ir_rx  = ~env_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx against a unit-level waveform model.
module tb_ir_nec_tx;

    localparam int U     = 4;
    localparam int CDIV  = 1;
    localparam int FRAME = 192 * U;
    localparam int NCHK  = FRAME + 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        send_rep = 1'b0;
    logic [15:0] tx_addr = '0;
    logic [7:0]  tx_cmd = '0;
    logic        busy, done, ir_env, ir_mod, ir_rx;

    int total = 0;
    int bad = 0;

    logic exp_env[NCHK];
    int   exp_ph[NCHK];
    logic obs_env[NCHK];
    int   mt;
    int   n_high, n_done, last_high;
    int   m_high, m_last;
    logic [31:0] dec;

    ir_nec_tx #(
        .UNIT_CYC   (U),
        .CARRIER_DIV(CDIV),
        .EXT_ADDR   (0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .send_rep(send_rep),
        .tx_addr (tx_addr),
        .tx_cmd  (tx_cmd),
        .busy    (busy),
        .done    (done),
        .ir_env  (ir_env),
        .ir_mod  (ir_mod),
        .ir_rx   (ir_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s @%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic put(input logic lvl, input int units);
        for (int i = 0; i < units * U; i++) begin
            exp_env[mt] = lvl;
            exp_ph[mt]  = i;
            mt++;
        end
    endtask

    // Expected envelope built from the protocol's unit timings.
    task automatic build(input logic rep, input logic [15:0] a, input logic [7:0] c);
        logic [7:0] by[4];
        for (int k = 0; k < NCHK; k++) begin
            exp_env[k] = 1'b0;
            exp_ph[k]  = 0;
        end
        mt = 0;
        put(1'b1, 16);
        if (rep) begin
            put(1'b0, 4);
        end else begin
            put(1'b0, 8);
            by[0] = a[7:0];
            by[1] = ~a[7:0];
            by[2] = c;
            by[3] = ~c;
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 8; i++) begin
                    put(1'b1, 1);
                    put(1'b0, by[j][i] ? 3 : 1);
                end
        end
        put(1'b1, 1);
        m_high = 0;
        m_last = -1;
        for (int k = 0; k < NCHK; k++)
            if (exp_env[k]) begin
                m_high++;
                m_last = k;
            end
    endtask

    task automatic run_frame(input logic st, input logic rp,
                             input logic [15:0] a, input logic [7:0] c,
                             input int poke_at);
        logic em;
        build(!st, a, c);
        @(posedge clk);
        #1;
        start    = st;
        send_rep = rp;
        tx_addr  = a;
        tx_cmd   = c;
        @(posedge clk);
        #1;
        start    = 1'b0;
        send_rep = 1'b0;
        tx_addr  = 16'($urandom);
        tx_cmd   = 8'($urandom);
        n_high = 0;
        n_done = 0;
        last_high = -1;
        for (int k = 0; k < NCHK; k++) begin
            @(negedge clk);
            obs_env[k] = ir_env;
            if (ir_env) begin
                n_high++;
                last_high = k;
            end
            if (done) n_done++;
            em = exp_env[k] && (((exp_ph[k] / CDIV) % 2) == 0);
            chk("ir_env", k, 32'(ir_env), 32'(exp_env[k]));
            chk("ir_rx",  k, 32'(ir_rx),  32'(!exp_env[k]));
            chk("ir_mod", k, 32'(ir_mod), 32'(em));
            chk("busy",   k, 32'(busy),   32'(k < FRAME));
            chk("done",   k, 32'(done),   32'(k == FRAME - 1));
            start = (k == poke_at);
        end
        start = 1'b0;
    endtask

    // Receiver-side decode of the observed envelope, decoder word layout.
    task automatic decode(output logic [31:0] data);
        logic [7:0] rb[4];
        int p;
        int s;
        p = 0;
        for (int j = 0; j < 4; j++) rb[j] = '0;
        while (p < NCHK && obs_env[p]) p++;
        while (p < NCHK && !obs_env[p]) p++;
        for (int b = 0; b < 32; b++) begin
            while (p < NCHK && obs_env[p]) p++;
            s = 0;
            while (p < NCHK && !obs_env[p]) begin
                s++;
                p++;
            end
            rb[b / 8][b % 8] = (s > 2 * U);
        end
        data = {rb[1], rb[0], rb[2], rb[3]};
    endtask

    initial begin
        #12;
        chk("rst_env",  0, 32'(ir_env), 32'd0);
        chk("rst_rx",   0, 32'(ir_rx),  32'd1);
        chk("rst_busy", 0, 32'(busy),   32'd0);
        chk("rst_done", 0, 32'(done),   32'd0);
        chk("rst_mod",  0, 32'(ir_mod), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Abort a frame during the first bit space.
        @(posedge clk);
        #1;
        start   = 1'b1;
        tx_addr = 16'h0004;
        tx_cmd  = 8'h08;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_busy", 100, 32'(busy),   32'd1);
        chk("pre_rst_env",  100, 32'(ir_env), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_env",  101, 32'(ir_env), 32'd0);
        chk("abort_rx",   101, 32'(ir_rx),  32'd1);
        chk("abort_busy", 101, 32'(busy),   32'd0);
        chk("abort_mod",  101, 32'(ir_mod), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_frame(1'b1, 1'b0, 16'h0004, 8'h08, -1);
        chk("model_high", 0, 32'(m_high), 32'd196);
        chk("model_last", 0, 32'(m_last), 32'd483);
        chk("frame_high", 0, 32'(n_high), 32'd196);
        chk("frame_last", 0, 32'(last_high), 32'd483);
        chk("frame_done", 0, 32'(n_done), 32'd1);
        decode(dec);
        chk("loop_data", 0, dec, 32'hFB0408F7);
        chk("loop_cmd",  0, 32'(dec[15:8]), 32'h08);

        run_frame(1'b0, 1'b1, 16'hBEEF, 8'h3C, -1);
        chk("model_rep_high", 0, 32'(m_high), 32'd68);
        chk("rep_high", 0, 32'(n_high), 32'd68);
        chk("rep_done", 0, 32'(n_done), 32'd1);

        run_frame(1'b1, 1'b1, 16'h1234, 8'hA5, 200);
        chk("both_high", 0, 32'(n_high), 32'(m_high));
        chk("both_done", 0, 32'(n_done), 32'd1);
        decode(dec);
        chk("both_data", 0, dec, 32'hCB34A55A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
